nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_if.sv | 38 +++
 rtl/nibble_serial_adder.sv | 121 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Purpose: request/result bundle between an adder client and nibble_serial_adder.
// Latency: none; wires only.
// Backpressure: start is held off by ready, and the result is held until ack.
// Optional: NSA_SUB_EN adds the sub (subtract select) signal.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NSA_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
`ifdef NSA_SUB_EN
    output sub,
`endif
    output start, a, b, cin, ack,
    input  ready, valid, sum, cout, zero, ovf
  );

  modport slave (
`ifdef NSA_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin, ack,
    output ready, valid, sum, cout, zero, ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Purpose: WIDTH-bit adder that processes one 4-bit slice per clock, with a registered ripple carry.
// Latency: valid rises WIDTH/4 edges after the accepting edge. One op per WIDTH/4+2 cycles at best.
// Backpressure: ready only in IDLE; the result is held in DONE until ack, and start is ignored there.
// Optional: NSA_SUB_EN adds sub, which computes a - b as a + ~b + 1.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  nibble_serial_adder_if.slave bus
);
  localparam int NS = WIDTH / 4;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, sum_r, sum_nxt, b_in;
  logic             carry, c_in, cout_r, zero_r, ovf_r;
  logic [KW-1:0]    k;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice;
  logic [NS-1:0]    nib_or;
  logic             last;

  // Operand conditioning at acceptance: subtraction is inverted B plus a forced carry-in.
  always_comb begin
    b_in = bus.b;
    c_in = bus.cin;
`ifdef NSA_SUB_EN
    if (bus.sub) begin
      b_in = ~bus.b;
      c_in = 1'b1;
    end
`endif
  end

  // Select the current slice, add it, and build the partial sum and per-nibble zero terms.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int i = 0; i < NS; i++) begin
      if (k == KW'(i)) begin
        a_nib = op_a[i*4 +: 4];
        b_nib = op_b[i*4 +: 4];
      end
    end
    slice   = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry};
    sum_nxt = sum_r;
    for (int i = 0; i < NS; i++) begin
      if (k == KW'(i)) sum_nxt[i*4 +: 4] = slice[3:0];
    end
    for (int i = 0; i < NS; i++) begin
      nib_or[i] = |sum_nxt[i*4 +: 4];
    end
    last = (k == KW'(NS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the handshake outputs decoded from the state.
  always_comb begin
    state_nxt = state;
    bus.ready = 1'b0;
    bus.valid = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.valid = 1'b1;
        if (bus.ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on acceptance, then one slice per edge. Flags are set on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        op_a  <= bus.a;
        op_b  <= b_in;
        carry <= c_in;
        k     <= '0;
        sum_r <= '0;
      end
    end else if (state == RUN) begin
      sum_r <= sum_nxt;
      carry <= slice[4];
      k     <= k + KW'(1);
      if (last) begin
        cout_r <= slice[4];
        zero_r <= ~|nib_or;
        ovf_r  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_nxt[WIDTH-1] != op_a[WIDTH-1]);
      end
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.zero = zero_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Purpose: directed and random checks of nibble_serial_adder against an arithmetic reference model.
// Latency: checks that valid rises exactly 4 edges after acceptance when WIDTH is 16.
// Backpressure: holds ack low in DONE, and covers start while busy and start together with ack.
// Optional: define NSA_SUB_EN to exercise subtraction.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic sub, output logic [15:0] s, output logic co,
                                output logic z, output logic ov);
    logic [16:0] full;
    int          sa;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      co   = (a >= b);
      sa   = int'($signed(a)) - int'($signed(b));
    end else begin
      full = {1'b0, a} + {1'b0, b} + 17'(cin);
      co   = full[16];
      sa   = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    s  = full[15:0];
    z  = (s == 16'd0);
    ov = (sa > 32767) || (sa < -32768);
  endfunction

  // Start one op, check the latency, then check the result. This leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
    logic [15:0] es;
    logic        ec, ez, eo;
    int          n;
    model(a, b, cin, sub, es, ec, ez, eo);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef NSA_SUB_EN
    bus.sub   = sub;
`endif
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check({tag, ".busy"}, 32'(bus.ready), 32'd0);
    n = 0;
    while (bus.valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd4);
    check({tag, ".sum"},  32'(bus.sum),  32'(es));
    check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
    check({tag, ".ovf"},  32'(bus.ovf),  32'(eo));
  endtask

  task automatic ack_op(input string tag);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check({tag, ".ack_ready"}, 32'(bus.ready), 32'd1);
    check({tag, ".ack_valid"}, 32'(bus.valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, held;
    logic        rc, rs;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.ack   = 1'b0;
`ifdef NSA_SUB_EN
    bus.sub   = 1'b0;
`endif
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    check("rst.ready", 32'(bus.ready), 32'd1);
    check("rst.valid", 32'(bus.valid), 32'd0);
    check("rst.sum",   32'(bus.sum),   32'd0);
    check("rst.cout",  32'(bus.cout),  32'd0);
    check("rst.zero",  32'(bus.zero),  32'd0);
    check("rst.ovf",   32'(bus.ovf),   32'd0);

    run_op("t2", 16'h1234, 16'h4321, 1'b0, 1'b0);
    check("t2.sum_const", 32'(bus.sum), 32'h5555);
    ack_op("t2");

    run_op("t3", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("t3.zero_const", 32'(bus.zero), 32'd1);
    ack_op("t3");

    // Hold the result with ack low while start pulses arrive. Finish with start and ack together.
    run_op("t4", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    check("t4.ovf_const", 32'(bus.ovf), 32'd1);
    held = bus.sum;
    for (int i = 0; i < 10; i++) begin
      bus.start = i[0];
      bus.a     = 16'($urandom);
      tick;
      check("t4.hold_valid", 32'(bus.valid), 32'd1);
      check("t4.hold_sum",   32'(bus.sum),   32'(held));
    end
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    check("t4.start_dropped", 32'(bus.ready), 32'd1);
    tick;
    check("t4.still_idle", 32'(bus.ready), 32'd1);
    check("t4.keep_sum",   32'(bus.sum),   32'h8000);

    // Reset in the middle of RUN must discard the op without a valid pulse.
    bus.a     = 16'hAAAA;
    bus.b     = 16'h5555;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t5.ready", 32'(bus.ready), 32'd1);
    check("t5.sum",   32'(bus.sum),   32'd0);
    check("t5.ovf",   32'(bus.ovf),   32'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("t5.no_valid", 32'(bus.valid), 32'd0);
    end
    run_op("t5b", 16'h0001, 16'h0001, 1'b0, 1'b0);
    check("t5b.sum_const", 32'(bus.sum), 32'h0002);
    ack_op("t5b");

`ifdef NSA_SUB_EN
    run_op("t6a", 16'h0005, 16'h0007, 1'b1, 1'b1);
    check("t6a.sum_const", 32'(bus.sum), 32'hFFFE);
    ack_op("t6a");
    run_op("t6b", 16'h8000, 16'h0001, 1'b0, 1'b1);
    check("t6b.ovf_const", 32'(bus.ovf), 32'd1);
    ack_op("t6b");
`endif

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? ~ra : 16'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef NSA_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op("rnd", ra, rb, rc, rs);
      repeat ($urandom_range(0, 3)) tick;
      check("rnd.wait_valid", 32'(bus.valid), 32'd1);
      ack_op("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
